id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register directly upstream of the EX-stage ALU.
- Captures decoded operands and control from ID and presents `alu_a`, `alu_b` and `alu_sel` to the ALU.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results.
- Supports stall (hold) and flush (bubble insertion). Holds forwarded data across multi-cycle stalls so that no in-flight result is lost.

---
 rtl/id_ex_operand_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding for the EX-stage ALU
//
// Purpose: captures decoded operands/control from ID, resolves RAW hazards by
// forwarding EX/MEM and MEM/WB results onto alu_a/alu_b/ex_store_data, and
// supports stall (hold) and flush (bubble insertion).
// Optional feature macro: EX_FORWARD_EN (forwarding + stall refresh). When it
// is undefined, the stored register values are used directly and fwd_a/fwd_b read 0.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   id_*                            decoded instruction fields from ID
//   stall, flush                    hold / bubble controls (flush beats stall)
//   exm_reg_write/exm_dest/exm_result   EX/MEM writeback candidate
//   wb_reg_write/wb_dest/wb_result      MEM/WB writeback candidate
//   ex_valid, ex_dest, ex_reg_write     stored control toward EX
//   alu_a, alu_b, alu_sel               ALU operands and op
//   ex_store_data                       forwarded rt value
//   fwd_a, fwd_b                        selected source: 0 reg, 1 MEM/WB, 2 EX/MEM

`ifndef ALU_SEL_ADD
`define ALU_SEL_ADD 2'd0
`endif
`ifndef ALU_SEL_SUB
`define ALU_SEL_SUB 2'd1
`endif
`ifndef ALU_SEL_AND
`define ALU_SEL_AND 2'd2
`endif
`ifndef ALU_SEL_OR
`define ALU_SEL_OR 2'd3
`endif

module id_ex_operand_stage #(
  parameter int DW = 32,  // the ALU is fixed at 32 bits
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alu_src,
  input  logic [1:0]    id_alu_sel,
  input  logic [RW-1:0] id_dest,
  input  logic          id_reg_write,
  input  logic          stall,
  input  logic          flush,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_dest,
  input  logic [DW-1:0] exm_result,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_dest,
  input  logic [DW-1:0] wb_result,
  output logic          ex_valid,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_sel,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);

  logic          s_valid;
  logic [RW-1:0] s_rs;
  logic [RW-1:0] s_rt;
  logic [DW-1:0] s_rs_val;
  logic [DW-1:0] s_rt_val;
  logic [DW-1:0] s_imm;
  logic          s_alu_src;
  logic [1:0]    s_alu_sel;
  logic [RW-1:0] s_dest;
  logic          s_reg_write;

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  // Flush loads the same image as reset: a bubble with zeroed indices and data.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s_valid     <= 1'b0;
      s_rs        <= '0;
      s_rt        <= '0;
      s_rs_val    <= '0;
      s_rt_val    <= '0;
      s_imm       <= '0;
      s_alu_src   <= 1'b0;
      s_alu_sel   <= `ALU_SEL_ADD;
      s_dest      <= '0;
      s_reg_write <= 1'b0;
    end else if (stall) begin
`ifdef EX_FORWARD_EN
      // Refresh: a producer that retires during the stall would otherwise
      // vanish from the bypass network before EX consumes the operand.
      s_rs_val <= op_a;
      s_rt_val <= op_b;
`endif
    end else begin
      s_valid     <= id_valid;
      s_rs        <= id_rs;
      s_rt        <= id_rt;
      s_rs_val    <= id_rs_val;
      s_rt_val    <= id_rt_val;
      s_imm       <= id_imm;
      s_alu_src   <= id_alu_src;
      s_alu_sel   <= id_alu_sel;
      s_dest      <= id_dest;
      s_reg_write <= id_reg_write;
    end
  end

`ifdef EX_FORWARD_EN
  // EX/MEM is younger than MEM/WB, so it wins; r0 is never bypassed.
  always_comb begin
    fwd_a = 2'd0;
    op_a  = s_rs_val;
    if (exm_reg_write && (exm_dest != '0) && (exm_dest == s_rs)) begin
      fwd_a = 2'd2;
      op_a  = exm_result;
    end else if (wb_reg_write && (wb_dest != '0) && (wb_dest == s_rs)) begin
      fwd_a = 2'd1;
      op_a  = wb_result;
    end
  end

  always_comb begin
    fwd_b = 2'd0;
    op_b  = s_rt_val;
    if (exm_reg_write && (exm_dest != '0) && (exm_dest == s_rt)) begin
      fwd_b = 2'd2;
      op_b  = exm_result;
    end else if (wb_reg_write && (wb_dest != '0) && (wb_dest == s_rt)) begin
      fwd_b = 2'd1;
      op_b  = wb_result;
    end
  end
`else
  logic unused_fwd_inputs;

  assign fwd_a = 2'd0;
  assign fwd_b = 2'd0;
  assign op_a  = s_rs_val;
  assign op_b  = s_rt_val;
  assign unused_fwd_inputs = ^{exm_reg_write, exm_dest, exm_result,
                               wb_reg_write, wb_dest, wb_result, s_rs, s_rt};
`endif

  assign ex_valid      = s_valid;
  assign alu_a         = op_a;
  assign alu_b         = s_alu_src ? s_imm : op_b;
  assign alu_sel       = s_alu_sel;
  assign ex_store_data = op_b;
  assign ex_dest       = s_dest;
  assign ex_reg_write  = s_reg_write & s_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage

`ifndef ALU_SEL_ADD
`define ALU_SEL_ADD 2'd0
`endif
`ifndef ALU_SEL_SUB
`define ALU_SEL_SUB 2'd1
`endif
`ifndef ALU_SEL_AND
`define ALU_SEL_AND 2'd2
`endif
`ifndef ALU_SEL_OR
`define ALU_SEL_OR 2'd3
`endif

module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_alu_src, id_reg_write, stall, flush;
  logic [4:0]  id_rs, id_rt, id_dest, exm_dest, wb_dest;
  logic [31:0] id_rs_val, id_rt_val, id_imm, exm_result, wb_result;
  logic [1:0]  id_alu_sel;
  logic        exm_reg_write, wb_reg_write;
  logic        ex_valid, ex_reg_write;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [1:0]  alu_sel, fwd_a, fwd_b;
  logic [4:0]  ex_dest;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_sel(id_alu_sel), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_dest(exm_dest), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  typedef struct {
    logic [31:0] rs_val, rt_val, imm;
    logic        src;
    logic [1:0]  sel;
    logic [4:0]  dest;
    logic        rw, v;
    logic [31:0] e_a, e_b;
    logic        e_rw;
  } vec_t;

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, dest;
    logic [31:0] rsv, rtv, imm;
    logic        src;
    logic [1:0]  sel;
    logic        rw;
  } st_t;

  vec_t vecs[4];
  st_t  m, mn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                        input logic src, input logic [1:0] sel, input logic [4:0] dest,
                        input logic rw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_val = rsv; id_rt_val = rtv;
    id_imm = imm; id_alu_src = src; id_alu_sel = sel; id_dest = dest; id_reg_write = rw;
  endtask

  task automatic clr_haz();
    exm_reg_write = 1'b0; exm_dest = 5'd0; exm_result = 32'd0;
    wb_reg_write  = 1'b0; wb_dest  = 5'd0; wb_result  = 32'd0;
  endtask

  // Operand source as seen by EX: the youngest in-flight producer of a nonzero
  // register supplies it; otherwise the value read in ID.
  function automatic void pick(input logic [4:0] idx, input logic [31:0] stored,
                               output logic [31:0] val, output logic [1:0] code);
    val  = stored;
    code = 2'd0;
`ifdef EX_FORWARD_EN
    begin
      logic        pw[2];
      logic [4:0]  pd[2];
      logic [31:0] pr[2];
      logic [1:0]  pc[2];
      pw[0] = exm_reg_write; pd[0] = exm_dest; pr[0] = exm_result; pc[0] = 2'd2;
      pw[1] = wb_reg_write;  pd[1] = wb_dest;  pr[1] = wb_result;  pc[1] = 2'd1;
      for (int k = 1; k >= 0; k--)
        if (pw[k] && idx != 5'd0 && pd[k] == idx) begin
          val  = pr[k];
          code = pc[k];
        end
    end
`endif
  endfunction

  initial begin
    logic [31:0] ea, eb;
    logic [1:0]  ca, cb;
    logic [31:0] held;

    vecs[0] = '{32'd5, 32'd7, 32'd0, 1'b0, `ALU_SEL_SUB, 5'd3, 1'b1, 1'b1, 32'd5, 32'd7, 1'b1};
    vecs[1] = '{32'hA, 32'hB, 32'hFFFF_FFFC, 1'b1, `ALU_SEL_AND, 5'd4, 1'b1, 1'b1, 32'hA, 32'hFFFF_FFFC, 1'b1};
    vecs[2] = '{32'd1, 32'd2, 32'd3, 1'b0, `ALU_SEL_OR, 5'd5, 1'b0, 1'b1, 32'd1, 32'd2, 1'b0};
    vecs[3] = '{32'd9, 32'd8, 32'd0, 1'b0, `ALU_SEL_ADD, 5'd6, 1'b1, 1'b0, 32'd9, 32'd8, 1'b0};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    clr_haz();
    set_id(1'b1, 5'd1, 5'd2, 32'hDEAD, 32'hBEEF, 32'h1, 1'b0, `ALU_SEL_OR, 5'd7, 1'b1);
    tick(); tick();
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_alu_sel", {30'd0, alu_sel}, {30'd0, `ALU_SEL_ADD});
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_b", alu_b, 32'd0);
    chk("reset_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("reset_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      set_id(vecs[i].v, 5'd1, 5'd2, vecs[i].rs_val, vecs[i].rt_val, vecs[i].imm,
             vecs[i].src, vecs[i].sel, vecs[i].dest, vecs[i].rw);
      tick();
      chk("vec_alu_a", alu_a, vecs[i].e_a);
      chk("vec_alu_b", alu_b, vecs[i].e_b);
      chk("vec_alu_sel", {30'd0, alu_sel}, {30'd0, vecs[i].sel});
      chk("vec_ex_dest", {27'd0, ex_dest}, {27'd0, vecs[i].dest});
      chk("vec_ex_reg_write", {31'd0, ex_reg_write}, {31'd0, vecs[i].e_rw});
      chk("vec_ex_valid", {31'd0, ex_valid}, {31'd0, vecs[i].v});
      chk("vec_store_data", ex_store_data, vecs[i].rt_val);
    end

    // forwarding priority
    set_id(1'b1, 5'd8, 5'd8, 32'h100, 32'h200, 32'd0, 1'b0, `ALU_SEL_ADD, 5'd9, 1'b1);
    tick();
    exm_reg_write = 1'b1; exm_dest = 5'd8; exm_result = 32'h11;
    wb_reg_write  = 1'b1; wb_dest  = 5'd8; wb_result  = 32'h22;
    #1;
`ifdef EX_FORWARD_EN
    chk("fwd_exm_a", alu_a, 32'h11);
    chk("fwd_exm_b", alu_b, 32'h11);
    chk("fwd_exm_code", {28'd0, fwd_a, fwd_b}, {28'd0, 2'd2, 2'd2});
    exm_reg_write = 1'b0;
    #1;
    chk("fwd_wb_a", alu_a, 32'h22);
    chk("fwd_wb_b", alu_b, 32'h22);
    chk("fwd_wb_code", {28'd0, fwd_a, fwd_b}, {28'd0, 2'd1, 2'd1});
`else
    chk("nofwd_a", alu_a, 32'h100);
    chk("nofwd_b", alu_b, 32'h200);
    chk("nofwd_code", {28'd0, fwd_a, fwd_b}, 32'd0);
`endif

    // register 0 never forwarded
    clr_haz();
    set_id(1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, `ALU_SEL_ADD, 5'd1, 1'b1);
    tick();
    exm_reg_write = 1'b1; exm_dest = 5'd0; exm_result = 32'hFFFF;
    #1;
    chk("r0_alu_a", alu_a, 32'd0);
    chk("r0_fwd_a", {30'd0, fwd_a}, 32'd0);

    // stall refresh
    clr_haz();
    set_id(1'b1, 5'd6, 5'd7, 32'h55, 32'h66, 32'd0, 1'b0, `ALU_SEL_SUB, 5'd10, 1'b1);
    tick();
    stall = 1'b1;
    wb_reg_write = 1'b1; wb_dest = 5'd6; wb_result = 32'h1234;
    set_id(1'b1, 5'd6, 5'd7, 32'h77, 32'h88, 32'd0, 1'b0, `ALU_SEL_OR, 5'd20, 1'b0);
`ifdef EX_FORWARD_EN
    held = 32'h1234;
`else
    held = 32'h55;
`endif
    #1;
    chk("stall_c1_alu_a", alu_a, held);
    tick();
    clr_haz();
    #1;
    chk("stall_c2_alu_a", alu_a, held);
    chk("stall_c2_dest", {27'd0, ex_dest}, 32'd10);
    tick();
    chk("stall_c3_alu_a", alu_a, held);
    chk("stall_c3_dest", {27'd0, ex_dest}, 32'd10);
    tick();
    stall = 1'b0;
    #1;
    chk("stall_rel_alu_a", alu_a, held);
    chk("stall_rel_dest", {27'd0, ex_dest}, 32'd10);
    chk("stall_rel_sel", {30'd0, alu_sel}, {30'd0, `ALU_SEL_SUB});

    // flush beats stall
    set_id(1'b1, 5'd1, 5'd2, 32'h3, 32'h4, 32'd0, 1'b0, `ALU_SEL_ADD, 5'd11, 1'b1);
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("flush_ex_dest", {27'd0, ex_dest}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // immediate path
    set_id(1'b1, 5'd3, 5'd4, 32'd1, 32'd2, 32'hFFFF_FFFC, 1'b1, `ALU_SEL_ADD, 5'd12, 1'b1);
    tick();
    exm_reg_write = 1'b1; exm_dest = 5'd4; exm_result = 32'hABCD;
    #1;
    chk("imm_alu_b", alu_b, 32'hFFFF_FFFC);
`ifdef EX_FORWARD_EN
    chk("imm_store_data", ex_store_data, 32'hABCD);
    chk("imm_fwd_b", {30'd0, fwd_b}, 32'd2);
`else
    chk("imm_store_data", ex_store_data, 32'd2);
`endif
    clr_haz();

    // reset mid-stall drops the held instruction
    stall = 1'b1; rst = 1'b1;
    tick();
    chk("rst_stall_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_stall_sel", {30'd0, alu_sel}, {30'd0, `ALU_SEL_ADD});
    chk("rst_stall_alu_b", alu_b, 32'd0);
    stall = 1'b0; rst = 1'b0;

    // randomized against the reference model
    m = '{default: '0};
    m.sel = `ALU_SEL_ADD;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 29) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      set_id(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom,
             $urandom, $urandom, 1'($urandom), 2'($urandom), 5'($urandom), 1'($urandom));
      exm_reg_write = 1'($urandom); exm_dest = 5'($urandom_range(0, 3)); exm_result = $urandom;
      wb_reg_write  = 1'($urandom); wb_dest  = 5'($urandom_range(0, 3)); wb_result  = $urandom;
      #1;
      pick(m.rs, m.rsv, ea, ca);
      pick(m.rt, m.rtv, eb, cb);
      chk("rnd_ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
      chk("rnd_ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.v & m.rw});
      chk("rnd_ex_dest", {27'd0, ex_dest}, {27'd0, m.dest});
      chk("rnd_alu_a", alu_a, ea);
      chk("rnd_alu_b", alu_b, m.src ? m.imm : eb);
      chk("rnd_store_data", ex_store_data, eb);
      chk("rnd_fwd", {28'd0, fwd_a, fwd_b}, {28'd0, ca, cb});
      if (m.v)
        chk("rnd_alu_sel", {30'd0, alu_sel}, {30'd0, m.sel});
      mn = m;
      if (rst || flush) begin
        mn = '{default: '0};
        mn.sel = `ALU_SEL_ADD;
      end else if (stall) begin
        mn.rsv = ea;
        mn.rtv = eb;
      end else begin
        mn = '{id_valid, id_rs, id_rt, id_dest, id_rs_val, id_rt_val, id_imm,
               id_alu_src, id_alu_sel, id_reg_write};
      end
      @(posedge clk);
      #1;
      m = mn;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
